// File: rtl/stream_fifo_4entry.sv
`default_nettype none
// ============================================================================
// Module   : stream_fifo_4entry
// Purpose  : First-word-fall-through FIFO placed after a valid/ready
//            pipeline. Lets the consumer stall without freezing the
//            pipeline. Its registered up_ready breaks the combinational
//            ready chain.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            up_data/valid/ready - write side (up_ready registered)
//            down_data/valid/ready - read side (down_valid registered,
//                                  down_data muxed from storage only)
//            level               - registered occupancy 0..DEPTH
//            almost_full         - registered, level >= AF_LEVEL
// Revision : 1.0 - initial release
// ============================================================================
module stream_fifo_4entry #(
  parameter int D_WIDTH  = 6,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [D_WIDTH-1:0]         up_data,
  input  logic                       up_valid,
  output logic                       up_ready,
  output logic [D_WIDTH-1:0]         down_data,
  output logic                       down_valid,
  input  logic                       down_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       almost_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] C_DEPTH = LW'(DEPTH);
  localparam logic [LW-1:0] C_AF    = LW'(AF_LEVEL);

  logic [D_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;

  logic               push;
  logic               pop;
  logic [LW-1:0]      level_next;

  // Handshakes only use registered status, so neither direction has a
  // combinational path from the opposite side's inputs.
  assign push = up_valid & up_ready;
  assign pop  = down_valid & down_ready;

  always_comb begin
    level_next = level;
    case ({push, pop})
      2'b10:   level_next = level + 1'b1;
      2'b01:   level_next = level - 1'b1;
      default: level_next = level;
    endcase
  end

  // Pointers, count and status flags. Status flags are registered from the
  // next-state count so they are exact in the cycle after each edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      up_ready    <= 1'b0;
      down_valid  <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level       <= level_next;
      up_ready    <= (level_next != C_DEPTH);
      down_valid  <= (level_next != '0);
      almost_full <= (level_next >= C_AF);
    end
  end

  // Storage is not reset; the write is gated so a handshake coinciding
  // with reset leaves no trace.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= up_data;
  end

  // No bypass: head data comes only from stored words.
  assign down_data = mem[rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_stream_fifo_4entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_fifo_4entry
// Purpose  : Directed self-checking bench for stream_fifo_4entry
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_fifo_4entry;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] up_data;
  logic       up_valid;
  logic       up_ready;
  logic [5:0] down_data;
  logic       down_valid;
  logic       down_ready;
  logic [2:0] level;
  logic       almost_full;

  int unsigned tests = 0;
  int unsigned fails = 0;

  stream_fifo_4entry #(.D_WIDTH(6), .DEPTH(4), .AF_LEVEL(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_data    (up_data),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .down_data  (down_data),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .level      (level),
    .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  // One rising edge, then land on the falling edge to sample and drive.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [5:0] q[$];
  logic [5:0] exp_w;
  logic       p_push, p_pop;
  int         sent, rcvd, cyc;

  initial begin
    rst = 1'b1; up_valid = 1'b0; up_data = '0; down_ready = 1'b0;

    // Reset for two cycles
    tick(); tick();
    chk("rst_up_ready", up_ready, 0);
    chk("rst_down_valid", down_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_af", almost_full, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_up_ready", up_ready, 1);
    chk("post_rst_level", level, 0);

    // Fill
    for (int k = 1; k <= 4; k++) begin
      up_valid = 1'b1; up_data = 6'(k);
      tick();
      chk("fill_level", level, k);
      chk("fill_af", almost_full, (k >= 3) ? 1 : 0);
      chk("fill_down_valid", down_valid, 1);
    end
    chk("full_up_ready", up_ready, 0);
    up_data = 6'h05;
    tick();
    chk("full_reject_level", level, 4);
    chk("full_reject_up_ready", up_ready, 0);
    chk("full_head", down_data, 6'h01);

    // Drain
    up_valid = 1'b0; down_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("drain_valid", down_valid, 1);
      chk("drain_data", down_data, k);
      tick();
      chk("drain_level", level, 4 - k);
      if (k == 1) chk("drain_up_ready_back", up_ready, 1);
    end
    chk("drain_empty_valid", down_valid, 0);
    chk("drain_empty_af", almost_full, 0);
    down_ready = 1'b0; up_valid = 1'b1; up_data = 6'h05;
    tick();
    up_valid = 1'b0;
    chk("fifth_valid", down_valid, 1);
    chk("fifth_data", down_data, 6'h05);
    chk("fifth_level", level, 1);
    down_ready = 1'b1;
    tick();
    down_ready = 1'b0;
    chk("fifth_popped", level, 0);

    // Simultaneous push/pop at level 2
    up_valid = 1'b1; up_data = 6'h10; tick();
    up_data = 6'h11; tick();
    chk("sim_start_level", level, 2);
    for (int i = 0; i < 10; i++) begin
      up_data = 6'(8'h12 + i); down_ready = 1'b1;
      chk("sim_data", down_data, 8'h10 + i);
      tick();
      chk("sim_level", level, 2);
    end
    up_valid = 1'b0;
    tick(); tick();
    down_ready = 1'b0;
    chk("sim_drained", level, 0);

    // Wrap-around with random handshakes, checked against a queue model
    q.delete(); sent = 0; rcvd = 0; cyc = 0;
    while (rcvd < 37 && cyc < 3000) begin
      up_valid   = (sent < 37) ? 1'($urandom_range(0, 1)) : 1'b0;
      up_data    = 6'(sent + 1);
      down_ready = 1'($urandom_range(0, 1));
      #1;
      p_push = up_valid & up_ready;
      p_pop  = down_valid & down_ready;
      if (p_pop) begin
        exp_w = (q.size() > 0) ? q.pop_front() : 6'h3f;
        chk("wrap_order", down_data, exp_w);
        rcvd++;
      end
      if (p_push) begin
        q.push_back(up_data);
        sent++;
      end
      tick();
      cyc++;
      chk("wrap_level", level, q.size());
      chk("wrap_level_max", (level <= 3'd4) ? 1 : 0, 1);
      chk("wrap_no_ready_full", (up_ready && level == 3'd4) ? 1 : 0, 0);
    end
    chk("wrap_done", rcvd, 37);
    up_valid = 1'b0; down_ready = 1'b1;
    repeat (5) tick();
    down_ready = 1'b0;
    chk("wrap_empty", level, 0);

    // Reset mid-operation at level 3
    up_valid = 1'b1;
    up_data = 6'h2A; tick();
    up_data = 6'h2B; tick();
    up_data = 6'h2C; tick();
    chk("mid_level3", level, 3);
    rst = 1'b1; up_data = 6'h3F; down_ready = 1'b1;
    tick();
    rst = 1'b0; up_valid = 1'b0; down_ready = 1'b0;
    chk("mid_rst_level", level, 0);
    chk("mid_rst_valid", down_valid, 0);
    tick();
    chk("mid_after_up_ready", up_ready, 1);
    chk("mid_after_valid", down_valid, 0);
    up_valid = 1'b1; up_data = 6'h15;
    tick();
    up_valid = 1'b0;
    chk("mid_new_level", level, 1);
    chk("mid_new_data", down_data, 6'h15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
